mem_responder: RTL



---
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Load/store request and response bus between the memory pipe (master) and mem_responder (slave).
// Handshake: a beat transfers on a rising edge where valid && ready are both high; the sender
// holds its payload stable while valid=1 and ready=0; ready never depends on the sender's valid.
interface mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [4:0]        req_regdest;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [4:0]        rsp_regdest;
  logic              rsp_write;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_regdest, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_regdest, rsp_write
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_regdest, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_regdest, rsp_write
  );
endinterface

// File: rtl/mem_responder.sv
// Data-memory responder: clears its array after reset, then serves in-order loads/stores with a
// fixed latency through a credit-limited response FIFO.
module mem_responder #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 7,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus,
  output logic           busy,
  output logic           dbg_state
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + LATENCY + 1) + 1;

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [4:0]        regdest;
    logic              write;
  } entry_t;

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  entry_t            r_pipe [LATENCY];
  logic [LATENCY-1:0] r_pipe_vld;
  entry_t            r_fifo [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_fifo_cnt;
  logic [CNT_W-1:0]  w_inflight;
  logic              w_req_ready, w_accept, w_push, w_pop;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  entry_t            w_new_entry;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT:  if (r_clr_cnt == {ADDR_W{1'b1}}) w_next_state = S_READY;
      S_READY: w_next_state = S_READY;
      default: w_next_state = S_INIT;
    endcase
  end

  // Credit check counts everything accepted but not yet popped, so the FIFO cannot overflow.
  always_comb begin
    w_req_ready = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = bus.req_addr;
    w_mem_wdata = bus.req_wdata;
    case (r_state)
      S_INIT: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_cnt;
        w_mem_wdata = '0;
      end
      S_READY: begin
        w_req_ready = (w_inflight + r_fifo_cnt) < CNT_W'(RSP_DEPTH);
        w_mem_we    = w_req_ready && bus.req_valid && bus.req_write;
      end
      default: ;
    endcase
    busy = (r_state == S_INIT) || (w_inflight != '0) || (r_fifo_cnt != '0);
  end

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) w_inflight = w_inflight + CNT_W'(r_pipe_vld[i]);
  end

  assign w_accept = bus.req_valid && w_req_ready;

  always_ff @(posedge clock) begin
    if (reset)                  r_clr_cnt <= '0;
    else if (r_state == S_INIT) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  // Loads read the array before a same-edge write; stores return a zero data word.
  always_comb begin
    w_new_entry.rdata   = bus.req_write ? '0 : r_mem[bus.req_addr];
    w_new_entry.regdest = bus.req_regdest;
    w_new_entry.write   = bus.req_write;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe_vld[0] <= w_accept;
      r_pipe[0]     <= w_new_entry;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe[i]     <= r_pipe[i-1];
      end
    end
  end

  assign w_push = r_pipe_vld[LATENCY-1];
  assign w_pop  = (r_fifo_cnt != '0) && bus.rsp_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_pipe[LATENCY-1];
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.rsp_valid   = (r_fifo_cnt != '0);
  assign bus.rsp_rdata   = r_fifo[r_rd_ptr].rdata;
  assign bus.rsp_regdest = r_fifo[r_rd_ptr].regdest;
  assign bus.rsp_write   = r_fifo[r_rd_ptr].write;
  assign dbg_state       = r_state;
endmodule
